// File: rtl/key_sched_if.sv
// Key-load and round-key read bundle between the key source / round datapath
// (master) and the AES-128 key schedule controller (slave).
interface key_sched_if;
  logic         key_valid;
  logic         key_ready;
  logic [127:0] key_in;
  logic         busy;
  logic         keys_valid;
  logic [3:0]   rk_idx;
  logic [127:0] rk_out;

  modport master (
    output key_valid, key_in, rk_idx,
    input  key_ready, busy, keys_valid, rk_out
  );

  modport slave (
    input  key_valid, key_in, rk_idx,
    output key_ready, busy, keys_valid, rk_out
  );
endinterface

// File: rtl/key_sched_ctrl.sv
// AES-128 key schedule controller: one key_expansion round per clock into an 11-entry bank.
// Optional macro KEY_SCHED_ZEROIZE_EN clears the bank on reset and on every key accept.
module key_sched_ctrl #(
  parameter int NUM_ROUNDS = 10
) (
  input logic        clk,
  input logic        rst,
  key_sched_if.slave bus
);

  localparam int         NUM_KEYS = NUM_ROUNDS + 1;
  localparam logic [3:0] LAST_CNT = 4'(NUM_ROUNDS - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_EXPAND = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      else      p = p;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (maps 0 to 0, as the S-box requires).
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r;
    r = x;
    for (int i = 0; i < 6; i++) begin
      r = gf_mul(gf_mul(r, r), x);
    end
    return gf_mul(r, r);
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] v;
    v = gf_inv(x);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd0:    return 8'h01;
      4'd1:    return 8'h02;
      4'd2:    return 8'h04;
      4'd3:    return 8'h08;
      4'd4:    return 8'h10;
      4'd5:    return 8'h20;
      4'd6:    return 8'h40;
      4'd7:    return 8'h80;
      4'd8:    return 8'h1b;
      4'd9:    return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // One AES-128 round of the key schedule: w3 rotated, substituted and rcon-mixed.
  function automatic logic [127:0] key_expansion(input logic [127:0] input_key,
                                                 input logic [3:0]   num_round);
    logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;
    {w0, w1, w2, w3} = input_key;
    t  = {sbox(w3[23:16]) ^ rcon(num_round), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
    n0 = w0 ^ t;
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  logic [1:0]   state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [127:0] rk_out_q, rk_out_d;
  logic [127:0] rk_q [NUM_KEYS];
  logic [127:0] rk_d [NUM_KEYS];
  logic [127:0] round_in_s;
  logic [127:0] round_out_s;
  logic         accept_s;

  assign accept_s = bus.key_valid && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  assign bus.key_ready  = (state_q != ST_EXPAND);
  assign bus.busy       = (state_q == ST_EXPAND);
  assign bus.keys_valid = (state_q == ST_DONE);
  assign bus.rk_out     = rk_out_q;

  // Select rk[cnt] as the round input and expand it.
  always_comb begin
    round_in_s = 128'h0;
    for (int i = 0; i < NUM_KEYS - 1; i++) begin
      round_in_s = (cnt_q == 4'(i)) ? rk_q[i] : round_in_s;
    end
    round_out_s = key_expansion(round_in_s, cnt_q);
  end

  // Next-state and round counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept_s) begin
          state_d = ST_EXPAND;
          cnt_d   = 4'd0;
        end else begin
          state_d = state_q;
        end
      end
      ST_EXPAND: begin
        if (cnt_q > LAST_CNT) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == LAST_CNT) begin
          state_d = ST_DONE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Bank update: load rk[0] on accept, write rk[cnt+1] while expanding.
  always_comb begin
    for (int i = 0; i < NUM_KEYS; i++) begin
      rk_d[i] = rk_q[i];
    end
    if (accept_s) begin
      rk_d[0] = bus.key_in;
`ifdef KEY_SCHED_ZEROIZE_EN
      for (int i = 1; i < NUM_KEYS; i++) begin
        rk_d[i] = 128'h0;
      end
`endif
    end else if ((state_q == ST_EXPAND) && (cnt_q <= LAST_CNT)) begin
      for (int i = 1; i < NUM_KEYS; i++) begin
        rk_d[i] = (cnt_q == 4'(i - 1)) ? round_out_s : rk_q[i];
      end
    end else begin
      rk_d[0] = rk_q[0];
    end
  end

  // Read port sees the pre-write bank contents.
  always_comb begin
    rk_out_d = 128'h0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      rk_out_d = (bus.rk_idx == 4'(i)) ? rk_q[i] : rk_out_d;
    end
  end

  // Control state and registered read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 4'd0;
      rk_out_q <= 128'h0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rk_out_q <= rk_out_d;
    end
  end

`ifdef KEY_SCHED_ZEROIZE_EN
  // Round key bank, cleared on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_KEYS; i++) rk_q[i] <= 128'h0;
    end else begin
      for (int i = 0; i < NUM_KEYS; i++) rk_q[i] <= rk_d[i];
    end
  end
`else
  // Round key bank, no reset: contents persist until overwritten.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_KEYS; i++) rk_q[i] <= rk_d[i];
  end
`endif

endmodule

// File: tb/tb_key_sched_ctrl.sv
// Directed bench for key_sched_ctrl using FIPS-197 and all-zero key expansion vectors.
module tb_key_sched_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  key_sched_if bus ();

  key_sched_ctrl #(.NUM_ROUNDS(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] FIPS_K0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_K1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_K2  = 128'hf2c295f27a96b9435935807a7359f67f;
  localparam logic [127:0] FIPS_K5  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
  localparam logic [127:0] FIPS_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_K0  = 128'h0;
  localparam logic [127:0] ZERO_K1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_K2  = 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa;
  localparam logic [127:0] ZERO_K10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic accept_key(input logic [127:0] k);
    bus.key_in    = k;
    bus.key_valid = 1'b1;
    cyc();
    bus.key_valid = 1'b0;
  endtask

  task automatic read_key(input logic [3:0] idx, output logic [127:0] data);
    bus.rk_idx = idx;
    cyc();
    data = bus.rk_out;
  endtask

  task automatic wait_done(input int start, output int n);
    n = start;
    while (bus.keys_valid !== 1'b1 && n < 30) begin
      cyc();
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.key_valid = 1'b0;
    bus.key_in = 128'h0;
    bus.rk_idx = 4'd0;
    cyc();
    cyc();
    checks++; if (bus.key_ready !== 1'b1) begin errors++; $display("FAIL reset_key_ready: got %b expected 1", bus.key_ready); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.keys_valid !== 1'b0) begin errors++; $display("FAIL reset_keys_valid: got %b expected 0", bus.keys_valid); end
    checks++; if (bus.rk_out !== 128'h0) begin errors++; $display("FAIL reset_rk_out: got %h expected 0", bus.rk_out); end
    rst = 1'b0;
  endtask

  task automatic test_fips();
    int n;
    logic [127:0] d;
    accept_key(FIPS_K0);
    checks++; if (bus.key_ready !== 1'b0) begin errors++; $display("FAIL fips_ready_low: got %b expected 0", bus.key_ready); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL fips_busy: got %b expected 1", bus.busy); end
    wait_done(0, n);
    checks++; if (n !== 10) begin errors++; $display("FAIL fips_latency: got %0d expected 10", n); end
    checks++; if (bus.key_ready !== 1'b1) begin errors++; $display("FAIL fips_ready_high: got %b expected 1", bus.key_ready); end
    read_key(4'd0, d);
    checks++; if (d !== FIPS_K0) begin errors++; $display("FAIL fips_rk0: got %h expected %h", d, FIPS_K0); end
    read_key(4'd1, d);
    checks++; if (d !== FIPS_K1) begin errors++; $display("FAIL fips_rk1: got %h expected %h", d, FIPS_K1); end
    read_key(4'd2, d);
    checks++; if (d !== FIPS_K2) begin errors++; $display("FAIL fips_rk2: got %h expected %h", d, FIPS_K2); end
    read_key(4'd10, d);
    checks++; if (d !== FIPS_K10) begin errors++; $display("FAIL fips_rk10: got %h expected %h", d, FIPS_K10); end
  endtask

  task automatic test_read_bounds();
    logic [127:0] d;
    read_key(4'd11, d);
    checks++; if (d !== 128'h0) begin errors++; $display("FAIL read_idx11: got %h expected 0", d); end
    read_key(4'd15, d);
    checks++; if (d !== 128'h0) begin errors++; $display("FAIL read_idx15: got %h expected 0", d); end
    for (int i = 0; i < 2; i++) begin
      bus.rk_idx = 4'd0;
      cyc();
      checks++; if (bus.rk_out !== FIPS_K0) begin errors++; $display("FAIL alt_rk0: got %h expected %h", bus.rk_out, FIPS_K0); end
      bus.rk_idx = 4'd10;
      #1;
      checks++; if (bus.rk_out !== FIPS_K0) begin errors++; $display("FAIL alt_latency: got %h expected %h", bus.rk_out, FIPS_K0); end
      cyc();
      checks++; if (bus.rk_out !== FIPS_K10) begin errors++; $display("FAIL alt_rk10: got %h expected %h", bus.rk_out, FIPS_K10); end
    end
  endtask

  task automatic test_restart();
    int n;
    logic [127:0] d;
    checks++; if (bus.keys_valid !== 1'b1) begin errors++; $display("FAIL restart_pre_valid: got %b expected 1", bus.keys_valid); end
    accept_key(ZERO_K0);
    checks++; if (bus.keys_valid !== 1'b0) begin errors++; $display("FAIL restart_valid_drop: got %b expected 0", bus.keys_valid); end
    bus.rk_idx = 4'd5;
    cyc();
`ifdef KEY_SCHED_ZEROIZE_EN
    checks++; if (bus.rk_out !== 128'h0) begin errors++; $display("FAIL zeroize_rk5: got %h expected 0", bus.rk_out); end
`else
    checks++; if (bus.rk_out !== FIPS_K5) begin errors++; $display("FAIL stale_rk5: got %h expected %h", bus.rk_out, FIPS_K5); end
`endif
    wait_done(1, n);
    checks++; if (n !== 10) begin errors++; $display("FAIL restart_latency: got %0d expected 10", n); end
    read_key(4'd0, d);
    checks++; if (d !== ZERO_K0) begin errors++; $display("FAIL restart_rk0: got %h expected %h", d, ZERO_K0); end
    read_key(4'd1, d);
    checks++; if (d !== ZERO_K1) begin errors++; $display("FAIL restart_rk1: got %h expected %h", d, ZERO_K1); end
    read_key(4'd2, d);
    checks++; if (d !== ZERO_K2) begin errors++; $display("FAIL restart_rk2: got %h expected %h", d, ZERO_K2); end
    read_key(4'd10, d);
    checks++; if (d !== ZERO_K10) begin errors++; $display("FAIL restart_rk10: got %h expected %h", d, ZERO_K10); end
  endtask

  task automatic test_holdoff();
    int n;
    logic [127:0] d;
    accept_key(FIPS_K0);
    cyc();
    cyc();
    bus.key_in = ZERO_K0;
    bus.key_valid = 1'b1;
    cyc();
    checks++; if (bus.key_ready !== 1'b0) begin errors++; $display("FAIL holdoff_t3_ready: got %b expected 0", bus.key_ready); end
    bus.key_valid = 1'b0;
    cyc();
    bus.key_valid = 1'b1;
    cyc();
    checks++; if (bus.key_ready !== 1'b0) begin errors++; $display("FAIL holdoff_t5_ready: got %b expected 0", bus.key_ready); end
    bus.key_valid = 1'b0;
    wait_done(5, n);
    checks++; if (n !== 10) begin errors++; $display("FAIL holdoff_latency: got %0d expected 10", n); end
    checks++; if (bus.key_ready !== 1'b1) begin errors++; $display("FAIL holdoff_ready_back: got %b expected 1", bus.key_ready); end
    read_key(4'd0, d);
    checks++; if (d !== FIPS_K0) begin errors++; $display("FAIL holdoff_rk0: got %h expected %h", d, FIPS_K0); end
    read_key(4'd1, d);
    checks++; if (d !== FIPS_K1) begin errors++; $display("FAIL holdoff_rk1: got %h expected %h", d, FIPS_K1); end
    read_key(4'd10, d);
    checks++; if (d !== FIPS_K10) begin errors++; $display("FAIL holdoff_rk10: got %h expected %h", d, FIPS_K10); end
  endtask

  task automatic test_reset_mid();
    int n;
    logic [127:0] d;
    bool_dummy: begin end
    accept_key(ZERO_K0);
    cyc();
    cyc();
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    checks++; if (bus.keys_valid !== 1'b0) begin errors++; $display("FAIL midrst_keys_valid: got %b expected 0", bus.keys_valid); end
    checks++; if (bus.key_ready !== 1'b1) begin errors++; $display("FAIL midrst_key_ready: got %b expected 1", bus.key_ready); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.rk_out !== 128'h0) begin errors++; $display("FAIL midrst_rk_out: got %h expected 0", bus.rk_out); end
    read_key(4'd2, d);
`ifdef KEY_SCHED_ZEROIZE_EN
    checks++; if (d !== 128'h0) begin errors++; $display("FAIL midrst_rk2_zero: got %h expected 0", d); end
`else
    checks++; if (d !== ZERO_K2) begin errors++; $display("FAIL midrst_rk2_stale: got %h expected %h", d, ZERO_K2); end
`endif
    for (int i = 0; i < 12; i++) cyc();
    checks++; if (bus.keys_valid !== 1'b0) begin errors++; $display("FAIL midrst_stays_invalid: got %b expected 0", bus.keys_valid); end
    accept_key(FIPS_K0);
    wait_done(0, n);
    checks++; if (n !== 10) begin errors++; $display("FAIL midrst_relatency: got %0d expected 10", n); end
    read_key(4'd10, d);
    checks++; if (d !== FIPS_K10) begin errors++; $display("FAIL midrst_rk10: got %h expected %h", d, FIPS_K10); end
  endtask

  initial begin
    test_reset();
    test_fips();
    test_read_bounds();
    test_restart();
    test_holdoff();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/key_sched_ctrl.md
# key_sched_ctrl

Sequences the combinational `key_expansion` round function to precompute all eleven AES-128 round keys from a cipher key and hold them in a register bank. It sits between the key-load interface and the encryption round datapath. The round datapath reads any round key by index with one-cycle latency. One `key_expansion` instance is reused iteratively, one round per clock.

## Interface
Parameters:
- `NUM_ROUNDS`, 10: number of expansion rounds; the bank holds `NUM_ROUNDS+1` keys. Only 10 is supported (AES-128).

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `key_valid`  in  1  cipher key offered on `key_in`.
- `key_ready`  out  1  controller can accept a key; reset value 1.
- `key_in`  in  128  cipher key; bits [127:96] are word w0.
- `busy`  out  1  expansion in progress; reset value 0.
- `keys_valid`  out  1  all round keys present and consistent with the last accepted key; reset value 0.
- `rk_idx`  in  4  round key index to read, 0..10.
- `rk_out`  out  128  registered round key read data; reset value 0.

## Operation
- FSM states: IDLE, EXPAND, DONE. Reset state is IDLE.
- Key acceptance happens on any edge where `key_valid && key_ready` is true.
- `key_ready` = (state != EXPAND).
- `busy` = (state == EXPAND).
- `keys_valid` = (state == DONE).
- Accept in IDLE or DONE:
  - `rk[0] <= key_in`.
  - Round counter `cnt <= 0`.
  - State goes to EXPAND.
  - An accept in DONE restarts expansion and drops `keys_valid` on that edge.
- EXPAND: the `key_expansion` instance is driven with `input_key = rk[cnt]` and `num_round = cnt`.
  - Each edge: `rk[cnt+1] <= output_key`, then `cnt <= cnt+1`.
  - On the edge that writes `rk[10]` (cnt==9), state goes to DONE and `cnt` returns to 0.
- `key_valid` is ignored during EXPAND. No key is accepted, buffered or dropped silently: the source must hold it until `key_ready`.
- `cnt` is 4 bits, range 0..9. Values 10..15 are unreachable; if reached, the FSM returns to IDLE.
- Read port: `rk_out <= (rk_idx <= 10) ? rk[rk_idx] : 128'h0` every cycle, independent of state.
  - A read during EXPAND returns whatever the bank holds at that time. The consumer must gate reads on `keys_valid`.
  - A read on the same edge as a bank write returns the pre-write value.
- Reset mid-expansion: on the next edge the state is IDLE, `cnt` is 0 and `keys_valid` is 0. The partial bank is never flagged valid.

## Timing
- Accept at edge T0 loads `rk[0]`.
- Edges T1..T10 write `rk[1]`..`rk[10]`.
- `keys_valid` is high after T10: expansion latency is 10 cycles from accept.
- `key_ready` is low after T0 through T10 and high again after T10.
- Back-to-back keys: the next accept can occur at T11 at the earliest.
- Read latency is 1 cycle: `rk_idx` sampled at edge N appears on `rk_out` after edge N.
- Critical path: `rk[cnt]` bank mux -> S-box -> XOR chain -> bank write. One round per cycle; no pipelining.

## Configuration
- `KEY_SCHED_ZEROIZE_EN` defined:
  - Reset clears all eleven bank entries to 0.
  - An accepted key clears `rk[1]`..`rk[10]` to 0 on the accept edge, alongside loading `rk[0]`.
  - As a result, no stale key material is readable at any time.
- Not defined:
  - Bank registers have no reset and are not cleared on accept; they hold prior contents until overwritten.
  - The FSM, `cnt` and all outputs still reset as specified.

## Test plan
- FIPS-197 key expansion:
  - Offer `key_in=2b7e151628aed2a6abf7158809cf4f3c` in IDLE.
  - Required: `keys_valid` rises exactly 10 cycles after accept.
  - Required: `rk_idx=1` reads `a0fafe1788542cb123a339392a6c7605`.
  - Required: `rk_idx=10` reads `d014f9a8c9ee2589e13f0cc8b6630ca6`.
  - Required: `rk_idx=0` reads the input key.
- Handshake hold-off:
  - Pulse `key_valid` with a different key at T3 and T5 during EXPAND.
  - Required: `key_ready` is 0 and the pulses are ignored.
  - Required: final keys match the first key.
  - Required: `key_ready` returns to 1 after T10.
- Restart from DONE:
  - Offer a new key with `keys_valid`=1.
  - Required: `keys_valid` drops after the accept edge and rises 10 cycles later.
  - Required: the bank matches the new key's expansion.
- Reset mid-expansion:
  - Assert `rst` at T4 for one cycle.
  - Required: state is IDLE, `keys_valid`=0, `key_ready`=1, `rk_out`=0.
  - With `KEY_SCHED_ZEROIZE_EN`, `rk_idx=2` reads 0.
- Read boundaries:
  - In DONE, `rk_idx=11` and `rk_idx=15` read 0.
  - Alternate `rk_idx` 0/10 each cycle: `rk_out` follows with 1-cycle latency.
- Zeroize on accept (macro defined):
  - Immediately after accepting a new key, at T1 read `rk_idx=5`.
  - Required: reads 0, not the previous key's round 5.
